icache_line_fill: RTL and testbench

- Miss-refill engine directly downstream of the instruction cache datapath, on the memory side.
- On a cache miss it fetches one full cache line as ICACHE_LINE_WIDTH/BUS_WIDTH sequential word reads over a valid/ready memory bus.
- It assembles the words into a line and presents it to the datapath's line-write input, with a one-cycle completion pulse that the cache controller uses to raise the cache write enable.

---
 rtl/icache_line_fill_pkg.sv | 18 +
 rtl/icache_line_fill_if.sv | 35 +++
 rtl/icache_line_fill.sv | 116 +++++++++++
 tb/tb_icache_line_fill.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_line_fill_pkg.sv
// Shared widths and FSM state type for the instruction-cache line-fill engine.
package icache_line_fill_pkg;

  localparam int unsigned ICACHE_ADDR_WIDTH  = 32;
  localparam int unsigned ICACHE_LINE_WIDTH  = 128;
  localparam int unsigned ICACHE_BUS_WIDTH   = 32;
  localparam int unsigned ICACHE_OFFSET_BITS = $clog2(ICACHE_LINE_WIDTH / 8);
  localparam int unsigned ICACHE_FILL_BEATS  = ICACHE_LINE_WIDTH / ICACHE_BUS_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DRAIN,
    DONE
  } type_icache_fill_states_e;

endpackage

// File: rtl/icache_line_fill_if.sv
// Cache-controller and memory-bus signals of the line-fill engine.
interface icache_line_fill_if
  import icache_line_fill_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH = ICACHE_LINE_WIDTH,
  parameter int unsigned BUS_WIDTH  = ICACHE_BUS_WIDTH
) ();

  logic                  icache2fill_req_i;
  logic [ADDR_WIDTH-1:0] icache2fill_addr_i;
  logic                  icache2fill_kill_i;
  logic                  fill2icache_ack_o;
  logic [LINE_WIDTH-1:0] fill2icache_data_o;
  logic                  fill2mem_req_o;
  logic [ADDR_WIDTH-1:0] fill2mem_addr_o;
  logic                  mem2fill_ready_i;
  logic                  mem2fill_valid_i;
  logic [BUS_WIDTH-1:0]  mem2fill_data_i;

  // Fill engine side.
  modport slave (
    input  icache2fill_req_i, icache2fill_addr_i, icache2fill_kill_i,
    input  mem2fill_ready_i, mem2fill_valid_i, mem2fill_data_i,
    output fill2icache_ack_o, fill2icache_data_o, fill2mem_req_o, fill2mem_addr_o
  );

  // Environment side (controller plus memory).
  modport master (
    output icache2fill_req_i, icache2fill_addr_i, icache2fill_kill_i,
    output mem2fill_ready_i, mem2fill_valid_i, mem2fill_data_i,
    input  fill2icache_ack_o, fill2icache_data_o, fill2mem_req_o, fill2mem_addr_o
  );

endinterface

// File: rtl/icache_line_fill.sv
// Miss-refill engine: fetches one cache line as ascending word reads and
// presents the assembled line with a one-cycle completion pulse.
module icache_line_fill
  import icache_line_fill_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH = ICACHE_LINE_WIDTH,
  parameter int unsigned BUS_WIDTH  = ICACHE_BUS_WIDTH
) (
  input logic               clk_i,
  input logic               rst_ni,
  icache_line_fill_if.slave bus
);

  localparam int unsigned BEATS       = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BUS_BYTES   = BUS_WIDTH / 8;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  type_icache_fill_states_e state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [LINE_WIDTH-1:0]    line_q, line_d;
  logic                     ack_q, ack_d;
  logic                     mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;

  // Next-state, beat sequencing and line slot assembly.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    line_d     = line_q;
    ack_d      = 1'b0;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    unique case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (bus.icache2fill_req_i && !bus.icache2fill_kill_i) begin
          state_d    = REQ;
          beat_d     = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {bus.icache2fill_addr_i[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
        end
      end

      REQ: begin
        if (bus.mem2fill_ready_i) begin
          mem_req_d = 1'b0;
          state_d   = bus.icache2fill_kill_i ? DRAIN : RESP;
        end else if (bus.icache2fill_kill_i) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      RESP: begin
        if (bus.icache2fill_kill_i) begin
          // A response arriving with the kill is the one being drained.
          state_d = bus.mem2fill_valid_i ? IDLE : DRAIN;
        end else if (bus.mem2fill_valid_i) begin
          line_d[32'(beat_q) * BUS_WIDTH +: BUS_WIDTH] = bus.mem2fill_data_i;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = DONE;
            ack_d   = 1'b1;
          end else begin
            beat_d     = beat_q + BEAT_W'(1);
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(BUS_BYTES);
          end
        end
      end

      DRAIN: begin
        if (bus.mem2fill_valid_i) begin
          state_d = IDLE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      line_q     <= '0;
      ack_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      ack_q      <= ack_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // A kill during the completion cycle must still be able to cancel the write.
  assign bus.fill2icache_ack_o  = ack_q & ~bus.icache2fill_kill_i;
  assign bus.fill2icache_data_o = line_q;
  assign bus.fill2mem_req_o     = mem_req_q;
  assign bus.fill2mem_addr_o    = mem_addr_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for the line-fill engine: inputs change and outputs are sampled on the falling edge.
module tb_icache_line_fill;
  import icache_line_fill_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   start;

  icache_line_fill_if #(
    .ADDR_WIDTH(ICACHE_ADDR_WIDTH),
    .LINE_WIDTH(ICACHE_LINE_WIDTH),
    .BUS_WIDTH (ICACHE_BUS_WIDTH)
  ) bus ();

  icache_line_fill dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One beat, entered where the request is visible: stall, accept, response gap, data.
  task automatic beat(input int req_wait, input int val_wait,
                      input logic [31:0] exp_addr, input logic [31:0] word);
    for (int i = 0; i < req_wait; i++) begin
      chk("stall_req", 128'(bus.fill2mem_req_o), 128'(1));
      chk("stall_addr", 128'(bus.fill2mem_addr_o), 128'(exp_addr));
      bus.mem2fill_ready_i = 1'b0;
      step();
    end
    chk("req", 128'(bus.fill2mem_req_o), 128'(1));
    chk("addr", 128'(bus.fill2mem_addr_o), 128'(exp_addr));
    bus.mem2fill_ready_i = 1'b1;
    step();
    bus.mem2fill_ready_i = 1'b0;
    for (int i = 0; i < val_wait; i++) begin
      chk("resp_wait_req", 128'(bus.fill2mem_req_o), 128'(0));
      step();
    end
    bus.mem2fill_valid_i = 1'b1;
    bus.mem2fill_data_i  = word;
    step();
    bus.mem2fill_valid_i = 1'b0;
    bus.mem2fill_data_i  = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.icache2fill_req_i  = 1'b0;
    bus.icache2fill_addr_i = 32'h0;
    bus.icache2fill_kill_i = 1'b0;
    bus.mem2fill_ready_i   = 1'b0;
    bus.mem2fill_valid_i   = 1'b0;
    bus.mem2fill_data_i    = 32'h0;

    // Reset state
    step();
    chk("rst_ack", 128'(bus.fill2icache_ack_o), 128'(0));
    chk("rst_req", 128'(bus.fill2mem_req_o), 128'(0));
    chk("rst_addr", 128'(bus.fill2mem_addr_o), 128'(0));
    chk("rst_line", bus.fill2icache_data_o, 128'(0));
    rst_n = 1'b1;
    step();

    // Basic fill
    start = cyc;
    bus.icache2fill_req_i  = 1'b1;
    bus.icache2fill_addr_i = 32'h8000_0014;
    step();
    beat(0, 0, 32'h8000_0010, 32'h1111_1111);
    beat(0, 0, 32'h8000_0014, 32'h2222_2222);
    beat(0, 0, 32'h8000_0018, 32'h3333_3333);
    beat(0, 0, 32'h8000_001C, 32'h4444_4444);
    chk("basic_latency", 128'(cyc - start), 128'(9));
    chk("basic_ack", 128'(bus.fill2icache_ack_o), 128'(1));
    chk("basic_line", bus.fill2icache_data_o, 128'h44444444_33333333_22222222_11111111);
    bus.icache2fill_req_i = 1'b0;
    step();
    chk("basic_ack_pulse", 128'(bus.fill2icache_ack_o), 128'(0));
    chk("basic_idle_req", 128'(bus.fill2mem_req_o), 128'(0));

    // Backpressure: valid late on beat 1, ready low on beat 2
    start = cyc;
    bus.icache2fill_req_i = 1'b1;
    step();
    beat(0, 0, 32'h8000_0010, 32'h1111_1111);
    beat(0, 2, 32'h8000_0014, 32'h2222_2222);
    beat(3, 0, 32'h8000_0018, 32'h3333_3333);
    beat(0, 0, 32'h8000_001C, 32'h4444_4444);
    chk("bp_latency", 128'(cyc - start), 128'(14));
    chk("bp_ack", 128'(bus.fill2icache_ack_o), 128'(1));
    chk("bp_line", bus.fill2icache_data_o, 128'h44444444_33333333_22222222_11111111);

    // req still high after completion restarts a fill
    step();
    chk("restart_idle_ack", 128'(bus.fill2icache_ack_o), 128'(0));
    chk("restart_idle_req", 128'(bus.fill2mem_req_o), 128'(0));
    step();
    chk("restart_req", 128'(bus.fill2mem_req_o), 128'(1));
    chk("restart_addr", 128'(bus.fill2mem_addr_o), 128'(32'h8000_0010));

    // Kill in REQ with ready low: straight back to idle
    bus.icache2fill_kill_i = 1'b1;
    bus.icache2fill_req_i  = 1'b0;
    step();
    bus.icache2fill_kill_i = 1'b0;
    chk("killreq0_req", 128'(bus.fill2mem_req_o), 128'(0));
    step();
    chk("killreq0_req_later", 128'(bus.fill2mem_req_o), 128'(0));
    chk("killreq0_ack", 128'(bus.fill2icache_ack_o), 128'(0));

    // Kill in RESP on beat 1, response arrives two cycles later
    bus.icache2fill_req_i  = 1'b1;
    bus.icache2fill_addr_i = 32'h0000_1008;
    step();
    beat(0, 0, 32'h0000_1000, 32'h5555_5555);
    chk("killresp_addr", 128'(bus.fill2mem_addr_o), 128'(32'h0000_1004));
    bus.mem2fill_ready_i = 1'b1;
    step();
    bus.mem2fill_ready_i   = 1'b0;
    bus.icache2fill_kill_i = 1'b1;
    bus.icache2fill_req_i  = 1'b0;
    step();
    bus.icache2fill_kill_i = 1'b0;
    chk("killresp_drain_req", 128'(bus.fill2mem_req_o), 128'(0));
    chk("killresp_drain_ack", 128'(bus.fill2icache_ack_o), 128'(0));
    bus.mem2fill_valid_i = 1'b1;
    bus.mem2fill_data_i  = 32'hDEAD_BEEF;
    step();
    bus.mem2fill_valid_i = 1'b0;
    chk("killresp_no_next_beat", 128'(bus.fill2mem_req_o), 128'(0));
    chk("killresp_no_ack", 128'(bus.fill2icache_ack_o), 128'(0));
    bus.icache2fill_req_i  = 1'b1;
    bus.icache2fill_addr_i = 32'h0000_0040;
    step();
    beat(0, 0, 32'h0000_0040, 32'hA0A0_A0A0);
    beat(0, 0, 32'h0000_0044, 32'hB1B1_B1B1);
    beat(0, 0, 32'h0000_0048, 32'hC2C2_C2C2);
    beat(0, 0, 32'h0000_004C, 32'hD3D3_D3D3);
    chk("refill_ack", 128'(bus.fill2icache_ack_o), 128'(1));
    chk("refill_line", bus.fill2icache_data_o, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
    bus.icache2fill_req_i = 1'b0;
    step();

    // Kill in REQ with ready high: accepted beat is drained, new request waits
    bus.icache2fill_req_i  = 1'b1;
    bus.icache2fill_addr_i = 32'h0000_0100;
    step();
    chk("killreq1_req", 128'(bus.fill2mem_req_o), 128'(1));
    bus.mem2fill_ready_i   = 1'b1;
    bus.icache2fill_kill_i = 1'b1;
    bus.icache2fill_req_i  = 1'b0;
    step();
    bus.mem2fill_ready_i   = 1'b0;
    bus.icache2fill_kill_i = 1'b0;
    bus.icache2fill_req_i  = 1'b1;
    bus.icache2fill_addr_i = 32'h0000_0200;
    chk("killreq1_drain_req", 128'(bus.fill2mem_req_o), 128'(0));
    step();
    chk("killreq1_drain_hold", 128'(bus.fill2mem_req_o), 128'(0));
    bus.mem2fill_valid_i = 1'b1;
    bus.mem2fill_data_i  = 32'hBAD0_BAD0;
    step();
    bus.mem2fill_valid_i = 1'b0;
    chk("killreq1_after_drain_req", 128'(bus.fill2mem_req_o), 128'(0));
    chk("killreq1_no_ack", 128'(bus.fill2icache_ack_o), 128'(0));
    step();
    beat(0, 0, 32'h0000_0200, 32'hCAFE_0000);
    beat(0, 0, 32'h0000_0204, 32'hCAFE_0001);
    beat(0, 0, 32'h0000_0208, 32'hCAFE_0002);
    beat(0, 0, 32'h0000_020C, 32'hCAFE_0003);
    chk("post_drain_line", bus.fill2icache_data_o, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);

    // Kill during the completion cycle suppresses the ack
    bus.icache2fill_kill_i = 1'b1;
    bus.icache2fill_req_i  = 1'b0;
    #1;
    chk("killdone_ack", 128'(bus.fill2icache_ack_o), 128'(0));
    step();
    bus.icache2fill_kill_i = 1'b0;
    chk("killdone_idle_req", 128'(bus.fill2mem_req_o), 128'(0));

    // Reset mid-beat 2, request held high afterwards
    bus.icache2fill_req_i  = 1'b1;
    bus.icache2fill_addr_i = 32'h0000_0500;
    step();
    beat(0, 0, 32'h0000_0500, 32'hFFFF_0000);
    beat(0, 0, 32'h0000_0504, 32'hFFFF_0001);
    bus.mem2fill_ready_i = 1'b1;
    step();
    bus.mem2fill_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 128'(bus.fill2mem_req_o), 128'(0));
    chk("midrst_addr", 128'(bus.fill2mem_addr_o), 128'(0));
    chk("midrst_ack", 128'(bus.fill2icache_ack_o), 128'(0));
    chk("midrst_line", bus.fill2icache_data_o, 128'(0));
    step();
    rst_n = 1'b1;
    step();
    beat(0, 0, 32'h0000_0500, 32'h0102_0304);
    beat(0, 0, 32'h0000_0504, 32'h0506_0708);
    beat(0, 0, 32'h0000_0508, 32'h090A_0B0C);
    beat(0, 0, 32'h0000_050C, 32'h0D0E_0F10);
    chk("postrst_ack", 128'(bus.fill2icache_ack_o), 128'(1));
    chk("postrst_line", bus.fill2icache_data_o, 128'h0D0E0F10_090A0B0C_05060708_01020304);
    bus.icache2fill_req_i = 1'b0;
    step();
    chk("final_ack", 128'(bus.fill2icache_ack_o), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
